// File: rtl/cosine_transformer_if.sv
// Pixel-in / coefficient-out stream bundle for the forward 8x8 DCT.
// The slave side is the transformer, the master side is the pixel source and quantizer.
interface cosine_transformer_if #(
    parameter int PIXEL_BIT = 8,
    parameter int Q_BIT     = 32,
    parameter int BLOCK_BIT = 3
);
    logic [PIXEL_BIT-1:0]    px_veri_i;
    logic [BLOCK_BIT-1:0]    px_row_i;
    logic [BLOCK_BIT-1:0]    px_col_i;
    logic                    px_gecerli_i;
    logic                    px_blok_son_i;
    logic                    px_hazir_o;
    logic signed [Q_BIT-1:0] q_veri_o;
    logic [BLOCK_BIT-1:0]    q_row_o;
    logic [BLOCK_BIT-1:0]    q_col_o;
    logic                    q_gecerli_o;
    logic                    q_blok_son_o;
    logic                    q_hazir_i;

    modport slave (
        input  px_veri_i, px_row_i, px_col_i, px_gecerli_i, px_blok_son_i, q_hazir_i,
        output px_hazir_o, q_veri_o, q_row_o, q_col_o, q_gecerli_o, q_blok_son_o
    );

    modport master (
        output px_veri_i, px_row_i, px_col_i, px_gecerli_i, px_blok_son_i, q_hazir_i,
        input  px_hazir_o, q_veri_o, q_row_o, q_col_o, q_gecerli_o, q_blok_son_o
    );
endinterface

// File: rtl/cosine_transformer.sv
// Forward 8x8 DCT-II: buffers a level-shifted pixel block, runs row then column passes
// on one shared 32x32 MAC and streams 64 Q16.16 coefficients in raster order.
module cosine_transformer #(
    parameter int PIXEL_BIT  = 8,
    parameter int Q_BIT      = 32,
    parameter int Q_FRAC_BIT = 16,
    parameter int BLOCK_SIZE = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    cosine_transformer_if.slave   bus
);
    localparam int BLOCK_BIT      = $clog2(BLOCK_SIZE);
    localparam int BLOCK_AREA     = BLOCK_SIZE * BLOCK_SIZE;
    localparam int BLOCK_AREA_BIT = 2 * BLOCK_BIT;
    localparam int CNT_BIT        = 3 * BLOCK_BIT;

    typedef enum logic [2:0] {HAZIRLA, DOLDUR, SATIR, SUTUN, GONDER} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [CNT_BIT-1:0]         r_cnt;
    logic [BLOCK_AREA_BIT-1:0]  r_ptr;
    logic signed [Q_BIT-1:0]    r_acc;
    logic signed [PIXEL_BIT:0]  r_pix  [BLOCK_AREA];
    logic signed [Q_BIT-1:0]    r_rbuf [BLOCK_AREA];
    logic signed [Q_BIT-1:0]    r_coef [BLOCK_AREA];

    logic [BLOCK_BIT-1:0]       w_inner;
    logic [BLOCK_BIT-1:0]       w_mid;
    logic [BLOCK_BIT-1:0]       w_outer;
    logic [BLOCK_BIT-1:0]       w_rom_k;
    logic signed [Q_BIT-1:0]    w_rom;
    logic signed [PIXEL_BIT:0]  w_pix_sel;
    logic signed [Q_BIT-1:0]    w_pix_q;
    logic signed [Q_BIT-1:0]    w_opnd;
    logic signed [2*Q_BIT-1:0]  w_prod;
    logic signed [Q_BIT-1:0]    w_mac;
    logic signed [Q_BIT-1:0]    w_acc_next;
    logic signed [PIXEL_BIT:0]  w_px_shift;
    logic [BLOCK_AREA_BIT-1:0]  w_wr_addr;
    logic                       w_cnt_last;

    // T[k][n] in Q16.16; (2n+1)k is folded into the first quadrant of cos(m*pi/16)
    function automatic logic signed [Q_BIT-1:0] cos_rom(input logic [2:0] k, input logic [2:0] n);
        logic [4:0]              m;
        logic [3:0]              f;
        logic                    neg;
        logic signed [Q_BIT-1:0] mag;
        m   = {1'b0, n, 1'b1} * {2'b00, k};
        neg = 1'b0;
        if (m > 5'd16) m = 5'd0 - m;
        if (m > 5'd8) begin
            neg = 1'b1;
            f   = 4'(5'd16 - m);
        end else begin
            f   = m[3:0];
        end
        case (f)
            4'd0:    mag = Q_BIT'(32768);
            4'd1:    mag = Q_BIT'(32138);
            4'd2:    mag = Q_BIT'(30274);
            4'd3:    mag = Q_BIT'(27246);
            4'd4:    mag = Q_BIT'(23170);
            4'd5:    mag = Q_BIT'(18205);
            4'd6:    mag = Q_BIT'(12540);
            4'd7:    mag = Q_BIT'(6393);
            default: mag = '0;
        endcase
        if (k == 3'd0) begin
            mag = Q_BIT'(23170);
            neg = 1'b0;
        end
        return neg ? -mag : mag;
    endfunction

    // Full 64-bit product, floor-truncated back to Q16.16
    function automatic logic signed [Q_BIT-1:0] q_trunc(input logic signed [2*Q_BIT-1:0] p);
        return Q_BIT'(p >>> Q_FRAC_BIT);
    endfunction

    assign w_inner    = r_cnt[BLOCK_BIT-1:0];
    assign w_mid      = r_cnt[2*BLOCK_BIT-1:BLOCK_BIT];
    assign w_outer    = r_cnt[CNT_BIT-1:2*BLOCK_BIT];
    assign w_cnt_last = &r_cnt;
    assign w_wr_addr  = r_cnt[CNT_BIT-1:BLOCK_BIT];

    // Row pass walks (y,u,x) over pixels; column pass walks (v,u,y) over R
    assign w_rom_k    = (r_state == SATIR) ? w_mid : w_outer;
    assign w_rom      = cos_rom(w_rom_k, w_inner);
    assign w_pix_sel  = r_pix[{w_outer, w_inner}];
    assign w_pix_q    = {{(Q_BIT-Q_FRAC_BIT-PIXEL_BIT-1){w_pix_sel[PIXEL_BIT]}}, w_pix_sel, {Q_FRAC_BIT{1'b0}}};
    assign w_opnd     = (r_state == SATIR) ? w_pix_q : r_rbuf[{w_inner, w_mid}];
    assign w_prod     = w_rom * w_opnd;
    assign w_mac      = q_trunc(w_prod);
    assign w_acc_next = (w_inner == '0) ? w_mac : r_acc + w_mac;
    assign w_px_shift = $signed({1'b0, bus.px_veri_i}) - $signed((PIXEL_BIT+1)'(1 << (PIXEL_BIT-1)));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= HAZIRLA;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HAZIRLA: w_next = DOLDUR;
            DOLDUR:  if (bus.px_gecerli_i && bus.px_blok_son_i) w_next = SATIR;
            SATIR:   if (w_cnt_last) w_next = SUTUN;
            SUTUN:   if (w_cnt_last) w_next = GONDER;
            GONDER:  if (bus.q_hazir_i && (&r_ptr)) w_next = HAZIRLA;
            default: w_next = HAZIRLA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
            r_ptr <= '0;
            r_acc <= '0;
            for (int i = 0; i < BLOCK_AREA; i++) begin
                r_pix[i]  <= '0;
                r_rbuf[i] <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            case (r_state)
                HAZIRLA: begin
                    r_cnt <= '0;
                    r_ptr <= '0;
                    r_acc <= '0;
                    for (int i = 0; i < BLOCK_AREA; i++) begin
                        r_pix[i]  <= '0;
                        r_rbuf[i] <= '0;
                    end
                end
                DOLDUR: begin
                    if (bus.px_gecerli_i) r_pix[{bus.px_row_i, bus.px_col_i}] <= w_px_shift;
                end
                SATIR: begin
                    r_cnt <= r_cnt + CNT_BIT'(1);
                    r_acc <= w_acc_next;
                    if (&w_inner) r_rbuf[w_wr_addr] <= w_acc_next;
                end
                SUTUN: begin
                    r_cnt <= r_cnt + CNT_BIT'(1);
                    r_acc <= w_acc_next;
                    if (&w_inner) r_coef[w_wr_addr] <= w_acc_next;
                end
                GONDER: begin
                    if (bus.q_hazir_i) r_ptr <= r_ptr + BLOCK_AREA_BIT'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.px_hazir_o   = (r_state == DOLDUR);
    assign bus.q_gecerli_o  = (r_state == GONDER);
    assign bus.q_blok_son_o = (r_state == GONDER) && (&r_ptr);
    assign bus.q_row_o      = r_ptr[BLOCK_AREA_BIT-1:BLOCK_BIT];
    assign bus.q_col_o      = r_ptr[BLOCK_BIT-1:0];
    assign bus.q_veri_o     = r_coef[r_ptr];
endmodule

// File: tb/tb_cosine_transformer.sv
// Scoreboarded bench for cosine_transformer: directed blocks, a reference DCT model
// built from real-valued cosines, hand constants, stall and mid-run reset cases.
module tb_cosine_transformer;
    logic clk_i  = 1'b0;
    logic rstn_i = 1'b1;
    always #5 clk_i = ~clk_i;

    cosine_transformer_if bus();
    cosine_transformer dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));

    typedef struct {
        int data;
        int row;
        int col;
        bit last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    tcos[8][8];
    int    s_img[64];
    int    rx[64];
    int    rx_n = 0;
    int    t_last = 0;
    bit    lat_armed = 1'b0;
    bit    stall_en = 1'b0;
    int    hz_ref = -100;
    bit    prev_stall = 1'b0;
    int    prev_data, prev_row, prev_col;
    bit    prev_last;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        longint d;
        d = longint'(act) - longint'(exp);
        check(name, (d <= tol) && (d >= -tol), act, exp);
    endtask

    function automatic int max_abs(input bit skip_dc);
        int m = 0;
        for (int i = 0; i < 64; i++) begin
            if (!(skip_dc && i == 0)) begin
                if (rx[i] > m) m = rx[i];
                if (-rx[i] > m) m = -rx[i];
            end
        end
        return m;
    endfunction

    task automatic build_rom();
        real a;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) begin
                a = (k == 0) ? $sqrt(0.125) : 0.5;
                tcos[k][n] = int'(a * $cos(real'((2*n+1)*k) * 3.14159265358979 / 16.0) * 65536.0);
            end
    endtask

    // Reference: separable DCT with floor-truncated Q16.16 products and 32-bit wrapping sums
    task automatic push_model();
        int     r[64];
        int     acc;
        longint p;
        beat_t  b;
        for (int y = 0; y < 8; y++)
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int x = 0; x < 8; x++) begin
                    p = longint'(tcos[u][x]) * (longint'(s_img[y*8+x]) * 65536);
                    acc += int'(p >>> 16);
                end
                r[y*8+u] = acc;
            end
        for (int v = 0; v < 8; v++)
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int y = 0; y < 8; y++) begin
                    p = longint'(tcos[v][y]) * longint'(r[y*8+u]);
                    acc += int'(p >>> 16);
                end
                b.data = acc; b.row = v; b.col = u; b.last = (v == 7 && u == 7);
                sb.push_back(b);
            end
    endtask

    task automatic clear_block();
        for (int i = 0; i < 64; i++) begin
            s_img[i] = 0;
            rx[i]    = 0;
        end
        rx_n = 0;
    endtask

    task automatic send_beat(input int r, input int c, input int v, input bit last);
        int n = 0;
        bus.px_row_i      = 3'(r);
        bus.px_col_i      = 3'(c);
        bus.px_veri_i     = 8'(v);
        bus.px_blok_son_i = last;
        bus.px_gecerli_i  = 1'b1;
        while (!bus.px_hazir_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        if (!bus.px_hazir_o) check("px_ready_timeout", 1'b0, n, 5000);
        @(posedge clk_i);
        if (last) begin
            t_last    = cyc;
            lat_armed = 1'b1;
        end
        s_img[r*8+c] = v - 128;
        #1;
        bus.px_gecerli_i  = 1'b0;
        bus.px_blok_son_i = 1'b0;
        if (last) push_model();
    endtask

    task automatic send_flat(input int v);
        for (int i = 0; i < 64; i++) send_beat(i / 8, i % 8, v, i == 63);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 6000) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_drain"}, sb.size() == 0, sb.size(), 0);
        check({name, "_beats"}, rx_n == 64, rx_n, 64);
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        bus.q_hazir_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            bus.q_hazir_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    always @(negedge clk_i) begin
        beat_t e;
        if (rstn_i) begin
            if (prev_stall) begin
                check("stall_hold", bus.q_gecerli_o && bus.q_veri_o == prev_data &&
                      int'(bus.q_row_o) == prev_row && int'(bus.q_col_o) == prev_col &&
                      bus.q_blok_son_o == prev_last, bus.q_veri_o, prev_data);
            end
            if (bus.q_gecerli_o && lat_armed) begin
                check("first_valid_latency", (cyc - t_last) == 1025, cyc - t_last, 1025);
                lat_armed = 1'b0;
            end
            if (cyc == hz_ref + 1) check("px_hazir_after_last_low", bus.px_hazir_o == 1'b0, bus.px_hazir_o, 0);
            if (cyc == hz_ref + 2) check("px_hazir_after_last_high", bus.px_hazir_o == 1'b1, bus.px_hazir_o, 1);
            if (bus.q_gecerli_o && bus.q_hazir_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1'b0, bus.q_veri_o, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("coef_v%0d_u%0d", e.row, e.col), bus.q_veri_o == e.data, bus.q_veri_o, e.data);
                    check($sformatf("index_v%0d_u%0d", e.row, e.col),
                          int'(bus.q_row_o) == e.row && int'(bus.q_col_o) == e.col && bus.q_blok_son_o == e.last,
                          {bus.q_row_o, bus.q_col_o, bus.q_blok_son_o}, {e.row[2:0], e.col[2:0], e.last});
                end
                rx[int'(bus.q_row_o)*8 + int'(bus.q_col_o)] = bus.q_veri_o;
                rx_n++;
                if (bus.q_blok_son_o) hz_ref = cyc;
            end
            prev_stall = bus.q_gecerli_o && !bus.q_hazir_i;
            prev_data  = bus.q_veri_o;
            prev_row   = int'(bus.q_row_o);
            prev_col   = int'(bus.q_col_o);
            prev_last  = bus.q_blok_son_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=%0d expected=<100000 cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ev_r[10] = '{0, 0, 2, 7, 0, 4, 5, 3, 6, 1};
        int ev_c[10] = '{0, 1, 3, 7, 0, 4, 2, 6, 1, 7};
        int ev_v[10] = '{200, 10, 77, 255, 30, 0, 150, 99, 1, 250};
        bus.px_veri_i     = '0;
        bus.px_row_i      = '0;
        bus.px_col_i      = '0;
        bus.px_gecerli_i  = 1'b0;
        bus.px_blok_son_i = 1'b0;
        build_rom();
        #1 rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outputs", !bus.px_hazir_o && !bus.q_gecerli_o && !bus.q_blok_son_o &&
              bus.q_veri_o == 0 && bus.q_row_o == 0 && bus.q_col_o == 0,
              {bus.px_hazir_o, bus.q_gecerli_o, bus.q_blok_son_o, bus.q_row_o, bus.q_col_o}, 0);
        @(negedge clk_i) rstn_i = 1'b1;

        // Mid-grey block: the level shift zeroes every sample
        clear_block();
        send_flat(128);
        wait_drain("flat128");
        check("flat128_all_zero", max_abs(1'b0) <= 8, max_abs(1'b0), 0);

        // Flat 255: DC ~ 127*8 = 1016.0; rounded ROM puts it ~0.04 below nominal
        clear_block();
        send_flat(255);
        wait_drain("flat255");
        check_near("flat255_dc", rx[0], 32'sh03F80000, 4096);
        check("flat255_ac_zero", max_abs(1'b1) <= 8, max_abs(1'b1), 0);

        clear_block();
        send_flat(0);
        wait_drain("flat0");
        check_near("flat0_dc", rx[0], 32'shFC000000, 4096);
        check("flat0_ac_zero", max_abs(1'b1) <= 8, max_abs(1'b1), 0);

        // Single bright pixel at (0,0), reverse raster: F00 = 127/8, F01 = F10 ~ 127*0.49*0.354
        clear_block();
        for (int i = 63; i >= 0; i--) send_beat(i / 8, i % 8, (i == 0) ? 255 : 128, i == 0);
        wait_drain("impulse");
        check_near("impulse_f00", rx[0], 1040384, 256);
        check_near("impulse_f01", rx[1], 1441792, 2048);
        check_near("impulse_f10", rx[8], 1441792, 2048);

        // Early end after 10 beats with one duplicate address; the rest of the block stays 0
        clear_block();
        for (int i = 0; i < 10; i++) send_beat(ev_r[i], ev_c[i], ev_v[i], i == 9);
        wait_drain("early_end");

        // Diagonal texture with random quantizer back-pressure
        clear_block();
        stall_en = 1'b1;
        for (int i = 0; i < 64; i++) send_beat(i / 8, i % 8, ((i / 8) * 29 + (i % 8) * 53 + 17) % 256, i == 63);
        repeat (300) @(negedge clk_i);
        check("busy_not_ready", !bus.px_hazir_o && !bus.q_gecerli_o, {bus.px_hazir_o, bus.q_gecerli_o}, 0);
        wait_drain("stalled");
        stall_en = 1'b0;

        // Reset pulse during the column pass, then a clean checkerboard block
        clear_block();
        for (int i = 0; i < 64; i++) send_beat(i / 8, i % 8, ((i / 8) ^ (i % 8)) * 30, i == 63);
        repeat (700) @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        check("midrun_reset_outputs", !bus.px_hazir_o && !bus.q_gecerli_o && !bus.q_blok_son_o &&
              bus.q_veri_o == 0 && bus.q_row_o == 0 && bus.q_col_o == 0, bus.q_veri_o, 0);
        sb.delete();
        lat_armed = 1'b0;
        @(negedge clk_i) rstn_i = 1'b1;
        clear_block();
        for (int i = 0; i < 64; i++) send_beat(i / 8, i % 8, (((i / 8) + (i % 8)) % 2 == 1) ? 240 : 16, i == 63);
        wait_drain("after_reset");

        repeat (5) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
